uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the payload bits per frame.
REQ-002 clk  input  1  Baud-rate clock; one line bit is transmitted per rising edge.
REQ-003 rst  input  1  Reset, asynchronous, active-low.
REQ-004 p_data  input  DATA_WIDTH  Parallel payload; sampled only on acceptance.
REQ-005 data_valid  input  1  Payload request; single-cycle or level.
REQ-006 par_en  input  1  1 = append a parity bit; sampled on acceptance.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-008 tx_out  output  1  Serial line; idle level is 1; registered.
REQ-009 busy  output  1  High while a frame is in flight; registered.

Function
REQ-010 The FSM SHALL use the states IDLE, START, DATA, PARITY and STOP, one-hot or binary encoded.
REQ-011 Acceptance SHALL occur when data_valid=1 in IDLE, or in STOP on its final cycle; otherwise data_valid is ignored and no request is queued.
REQ-012 On acceptance, p_data, par_en and par_typ SHALL be latched into internal registers; later input changes SHALL not affect the frame in flight.
REQ-013 For acceptance at edge N: tx_out=0 (start bit) and busy=1 SHALL appear after edge N, so latency from the request edge to the start bit is 1 cycle.
REQ-014 DATA SHALL drive DATA_WIDTH bits LSB-first, one per cycle, using a bit counter of width clog2(DATA_WIDTH).
REQ-015 DATA SHALL go to PARITY after the last bit when the latched par_en=1, else directly to STOP.
REQ-016 The PARITY bit SHALL be XOR-reduce(latched data) for even parity, or its inverse for odd parity.
REQ-017 STOP SHALL drive tx_out=1 for exactly 1 cycle.
REQ-018 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 without.
REQ-019 Back-to-back: acceptance in STOP SHALL move to START on the next edge; busy stays 1 and no idle bit is inserted.
REQ-020 Without acceptance in STOP, the next state SHALL be IDLE, with tx_out=1 and busy=0 after that edge.
REQ-021 In IDLE, tx_out SHALL be held at 1 with no glitches; tx_out SHALL be a flop output and never a combinational mux output.
REQ-022 An unreachable state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, tx_out=1, busy=0, clear the bit counter and clear the latched data/config registers, including mid-frame.
REQ-024 After rst deasserts, the first possible acceptance SHALL be at the first rising clk edge with data_valid=1.

Structure
REQ-025 A shared package SHALL hold the state typedef/encodings, the DATA_WIDTH default, and the parity-type constants (PAR_EVEN=0, PAR_ODD=1).
REQ-026 Parity generation SHALL be a sub-module tx_par_gen (latched data and par_typ in, parity bit out, combinational); the FSM, counter, shift register and output mux SHALL stay in uart_tx_ctrl.

Verification
REQ-027 Reset, then p_data=0xA5, par_en=1, par_typ=0, one-cycle valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles.
REQ-028 Same frame with par_typ=1 -> parity bit 1; all other bits unchanged.
REQ-029 p_data=0x00, par_en=0 -> tx_out 0 then eight 0s then 1, which is 10 cycles; busy falls after the stop bit.
REQ-030 Assert data_valid during the STOP of frame 0x3C; change p_data to 0xFF mid-frame -> frame 1 sends 0x3C intact, frame 2 sends 0xFF, and its start bit immediately follows the stop bit with no idle gap.
REQ-031 Pulse data_valid during the DATA state -> the pulse is ignored and no extra frame follows.
REQ-032 Assert rst during DATA bit 4 -> tx_out=1 and busy=0 without waiting for clk; the next request produces a complete correct frame.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | uart_tx_ctrl_pkg : shared types/constants for the UART transmitter |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package uart_tx_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tx_par_gen.sv
// +------------------------------------------------------------------+
// | tx_par_gen : combinational parity bit for the latched payload     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tx_par_gen
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  logic w_xor;

  assign w_xor   = ^data;
  assign par_bit = (par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// +------------------------------------------------------------------+
// | uart_tx_ctrl : UART frame serialiser, one line bit per clk        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int                c_cnt_w    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_par;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;

  assign w_accept = data_valid && ((r_state == ST_IDLE) || (r_state == ST_STOP));
  assign w_last   = (r_cnt == c_last_bit);

  tx_par_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_par_gen (
    .data    (r_data),
    .par_typ (r_par_typ),
    .par_bit (w_par)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next = w_accept ? ST_START : ST_IDLE;
      ST_START:  w_next = ST_DATA;
      ST_DATA:   w_next = !w_last ? ST_DATA : (r_par_en ? ST_PARITY : ST_STOP);
      ST_PARITY: w_next = ST_STOP;
      ST_STOP:   w_next = w_accept ? ST_START : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Line value is decoded from the upcoming state so tx_out itself is a flop.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b0;
    case (w_next)
      ST_START:  begin w_tx_nxt = 1'b0;       w_busy_nxt = 1'b1; end
      ST_DATA:   begin w_tx_nxt = r_shift[0]; w_busy_nxt = 1'b1; end
      ST_PARITY: begin w_tx_nxt = w_par;      w_busy_nxt = 1'b1; end
      ST_STOP:   begin w_tx_nxt = 1'b1;       w_busy_nxt = 1'b1; end
      default:   begin w_tx_nxt = 1'b1;       w_busy_nxt = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_data    <= '0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_data    <= p_data;
        r_shift   <= p_data;
        r_par_en  <= par_en;
        r_par_typ <= par_typ;
      end else if (w_next == ST_DATA) begin
        // Bit 0 is loaded into r_tx on this same edge, so advance to the next bit.
        r_shift <= r_shift >> 1;
      end
      if ((r_state == ST_DATA) && !w_last) r_cnt <= r_cnt + c_cnt_one;
      else                                 r_cnt <= '0;
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// +------------------------------------------------------------------+
// | tb_uart_tx_ctrl : directed, table-driven bench for uart_tx_ctrl   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       tx_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // seq holds the expected line bits, first bit transmitted at seq[10].
  typedef struct {
    logic [7:0]  d;
    logic        en;
    logic        typ;
    logic [10:0] seq;
    int          len;
    int          pulse_at;
  } vec_t;

  vec_t vecs[6];

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " idle tx"}, tx_out, 1'b1);
    chk({nm, " idle busy"}, busy, 1'b0);
  endtask

  // Called at a falling edge; the request is accepted on the following rising edge.
  task automatic send_req(input logic [7:0] d, input logic en, input logic typ);
    p_data     = d;
    par_en     = en;
    par_typ    = typ;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [10:0] seq, input int len,
                             input logic [7:0] md, input logic men, input logic mtyp,
                             input logic chain, input int pulse_at);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", nm, i), tx_out, seq[10-i]);
      chk($sformatf("%s busy[%0d]", nm, i), busy, 1'b1);
      if (i == 3) begin
        p_data  = md;
        par_en  = men;
        par_typ = mtyp;
      end
      if ((chain && (i == len - 1)) || (i == pulse_at)) data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
    end
    if (!chain) chk_idle(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, -1};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, -1};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 11'b00000000010, 10, -1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 11'b00011110010, 10,  4};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 11'b01111111111, 11, -1};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 11'b01000000011, 11,  6};

    // Reset state, forced asynchronously
    #1 rst = 1'b0;
    #1;
    chk("reset tx", tx_out, 1'b1);
    chk("reset busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk_idle("post-reset");

    // Table-driven frames; inputs are scrambled mid-frame to prove latching
    for (int v = 0; v < 6; v++) begin
      send_req(vecs[v].d, vecs[v].en, vecs[v].typ);
      check_frame($sformatf("vec%0d", v), vecs[v].seq, vecs[v].len,
                  ~vecs[v].d, ~vecs[v].en, ~vecs[v].typ, 1'b0, vecs[v].pulse_at);
      @(negedge clk);
      chk_idle($sformatf("vec%0d +1", v));
      @(negedge clk);
      chk_idle($sformatf("vec%0d +2", v));
    end

    // Back-to-back: 0x3C then 0xFF (odd parity) requested during STOP
    send_req(8'h3C, 1'b0, 1'b0);
    check_frame("b2b frame1", 11'b00011110010, 10, 8'hFF, 1'b1, 1'b1, 1'b1, -1);
    check_frame("b2b frame2", 11'b01111111111, 11, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk_idle("b2b tail");

    // Asynchronous reset during DATA bit 4 of an 0xA5 frame
    send_req(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("pre-reset tx bit4", tx_out, 1'b0);
    chk("pre-reset busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midframe reset tx", tx_out, 1'b1);
    chk("midframe reset busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    chk_idle("after midframe reset");
    send_req(8'h01, 1'b1, 1'b0);
    check_frame("post-reset frame", 11'b01000000011, 11, 8'h00, 1'b0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
